// File: rtl/fifo_shift_ctrl.sv
// fifo_shift_ctrl: drives an external 8-bit synchronous fifo_shift as a
// one-line pixel delay. Each frame it drains the FIFO (FLUSH), pre-fills one
// line of IMG_WIDTH pixels (FILL), then writes and reads in lock-step on every
// valid pixel (SHIFT). The current pixel is emitted next to the pixel from the
// same column one line earlier.
// Optional feature macro: FIFO_SHIFT_CTRL_LVL_CHK_EN (FIFO water-level check
// on SHIFT writes, reported on err_lvl; tied 0 when undefined).
//
// Handshake: pix_vld is a pure valid with no ready. Every cycle with pix_vld=1
// carries one pixel that is either consumed (FILL/SHIFT) or dropped
// (IDLE/FLUSH/frame-start cycle); the controller never stalls the source.
module fifo_shift_ctrl #(
  parameter int IMG_WIDTH = 640,
  parameter int DATA_W    = 8,
  parameter int DEPTH_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vs_i,
  input  logic              pix_vld,
  input  logic [DATA_W-1:0] pix_data,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DEPTH_W:0]  fifo_water_level,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_cur,
  output logic [DATA_W-1:0] out_dly,
  output logic              out_eol,
  output logic              busy_flush,
  output logic              err_ovf,
  output logic              err_udf,
  output logic              err_lvl,
  output logic [1:0]        dbg_state
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FILL  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              vs_q;
  logic              vs_edge;
  logic [COL_W-1:0]  col_q, col_d;
  logic              wr_en, rd_en, shift_vld;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_cur_q, out_cur_d;
  logic              out_eol_q, out_eol_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_udf_q, err_udf_d;

  // Frame start detect and FSM next-state / FIFO enables / column counter.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    shift_vld = 1'b0;
    vs_edge   = vs_i & ~vs_q;
    if (vs_edge) begin
      // The pixel in the edge cycle is dropped; no FIFO access this cycle.
      state_d = ST_FLUSH;
      col_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_FLUSH: begin
          rd_en = ~fifo_empty;
          if (fifo_empty) state_d = ST_FILL;
        end
        ST_FILL: begin
          if (pix_vld) begin
            wr_en = 1'b1;
            if (col_q == COL_LAST) begin
              col_d   = '0;
              state_d = ST_SHIFT;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
        ST_SHIFT: begin
          if (pix_vld) begin
            wr_en     = 1'b1;
            rd_en     = 1'b1;
            shift_vld = 1'b1;
            col_d     = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // No FIFO traffic while reset is asserted, whatever state the flops hold.
    if (!rst_n) begin
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      shift_vld = 1'b0;
    end
  end

  // Output pipeline and sticky error flag next values.
  always_comb begin
    out_vld_d = shift_vld;
    out_cur_d = pix_data;
    out_eol_d = shift_vld & (col_q == COL_LAST);
    err_ovf_d = err_ovf_q | (wr_en & fifo_full);
    err_udf_d = err_udf_q | (shift_vld & fifo_empty);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vs_q      <= 1'b0;
      col_q     <= '0;
      out_vld_q <= 1'b0;
      out_cur_q <= '0;
      out_eol_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_i;
      col_q     <= col_d;
      out_vld_q <= out_vld_d;
      out_cur_q <= out_cur_d;
      out_eol_q <= out_eol_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

`ifdef FIFO_SHIFT_CTRL_LVL_CHK_EN
  localparam logic [DEPTH_W:0] LVL_REF = (DEPTH_W + 1)'(IMG_WIDTH);

  logic lvl_chk_q, lvl_chk_d;
  logic err_lvl_q, err_lvl_d;

  // The level is compared one cycle after each SHIFT write so the FIFO's
  // water level has settled.
  always_comb begin
    lvl_chk_d = shift_vld;
    err_lvl_d = err_lvl_q | (lvl_chk_q & (fifo_water_level != LVL_REF));
  end

  // Level-check pipeline and sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_chk_q <= 1'b0;
      err_lvl_q <= 1'b0;
    end else begin
      lvl_chk_q <= lvl_chk_d;
      err_lvl_q <= err_lvl_d;
    end
  end

  assign err_lvl = err_lvl_q;
`else
  logic unused_water_level;
  assign unused_water_level = ^fifo_water_level;
  assign err_lvl            = 1'b0;
`endif

  assign fifo_wr_en   = wr_en;
  assign fifo_wr_data = pix_data;
  assign fifo_rd_en   = rd_en;
  assign out_vld      = out_vld_q;
  assign out_cur      = out_cur_q;
  // FIFO read latency is one cycle, so its output lines up with out_vld.
  assign out_dly      = fifo_rd_data;
  assign out_eol      = out_eol_q;
  assign busy_flush   = (state_q == ST_FLUSH);
  assign err_ovf      = err_ovf_q;
  assign err_udf      = err_udf_q;
  assign dbg_state    = state_q;

endmodule
